channel_array_ctrl: RTL and testbench

CHANNEL_ARRAY_CTRL -- requirements
Module: channel_array_ctrl

---
 rtl/channel_ctrl_pkg.sv | 41 ++++
 rtl/channel_fsm.sv | 179 +++++++++++++++++
 rtl/channel_array_ctrl.sv | 158 +++++++++++++++
 tb/tb_channel_array_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// channel_ctrl_pkg
// Shared types for the channel array controller:
//   ch_state_e   - per-channel sequencer state
//   trig_mode_e  - trigger source selection (values 0..3)
//   event_rec_t  - event record (channel id, ADC code, timestamp). Fields are
//                  sized for the widest supported build; narrower builds
//                  zero-extend into them and slice back out.
// ---------------------------------------------------------------------------
package channel_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SAMPLE,
        ST_CONVERT,
        ST_READY,
        ST_RESET
    } ch_state_e;

    typedef enum logic [1:0] {
        MODE_SELF     = 2'd0,
        MODE_EXT      = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_OFF      = 2'd3
    } trig_mode_e;

    localparam int CHAN_MAX_W = 8;
    localparam int ADC_MAX_W  = 16;
    localparam int TS_MAX_W   = 32;

    // Shared width of the per-channel phase counter (HOLD / CONVERT / RESET).
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [CHAN_MAX_W-1:0] chan;
        logic [ADC_MAX_W-1:0]  adc;
        logic [TS_MAX_W-1:0]   ts;
    } event_rec_t;

endpackage

// File: rtl/channel_fsm.sv
// ---------------------------------------------------------------------------
// channel_fsm
// One analog channel: hit synchronizer + edge detector, trigger selection,
// IDLE/HOLD/SAMPLE/CONVERT/READY/RESET sequencer, SAR register and
// timestamp capture.
// Ports:
//   clk, reset        clock, async active-high reset
//   hit               raw discriminator output (asynchronous)
//   comp              comparator decision for the current dac_word
//   mode, ext_trig    trigger mode and external trigger
//   per_tick          periodic trigger pulse from the top level
//   masked            channel disabled for new triggers
//   ts                free-running timestamp
//   ack               record for this channel was transferred downstream
//   sample, strobe, csa_reset, dac_word   analog front-end controls
//   ready, result, ts_cap                 record data towards the arbiter
// ---------------------------------------------------------------------------
module channel_fsm
    import channel_ctrl_pkg::*;
#(
    parameter int ADCBITS      = 10,
    parameter int TS_BITS      = 16,
    parameter int HOLD_CYCLES  = 2,
    parameter int RESET_CYCLES = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               hit,
    input  logic               comp,
    input  logic [1:0]         mode,
    input  logic               ext_trig,
    input  logic               per_tick,
    input  logic               masked,
    input  logic [TS_BITS-1:0] ts,
    input  logic               ack,
    output logic               sample,
    output logic               strobe,
    output logic               csa_reset,
    output logic [ADCBITS-1:0] dac_word,
    output logic               ready,
    output logic [ADCBITS-1:0] result,
    output logic [TS_BITS-1:0] ts_cap
);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CONV_LAST = CNT_W'(ADCBITS - 1);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [ADCBITS-1:0] MSB       = {1'b1, {(ADCBITS-1){1'b0}}};

    ch_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADCBITS-1:0] sar_q, sar_d;
    logic [TS_BITS-1:0] ts_cap_q, ts_cap_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic               edge_q, edge_d;
    logic               trig;
    logic [ADCBITS-1:0] trial;

    // Trial bit for CONVERT cycle i walks from the MSB downwards.
    assign trial = MSB >> cnt_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sar_q    <= '0;
            ts_cap_q <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sar_q    <= sar_d;
            ts_cap_q <= ts_cap_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            edge_q   <= edge_d;
        end
    end

    // Trigger source; the mask gates only new triggers so a channel already
    // in flight still runs to completion.
    always_comb begin
        trig = 1'b0;
        case (trig_mode_e'(mode))
            MODE_SELF:     trig = edge_q;
            MODE_EXT:      trig = ext_trig;
            MODE_PERIODIC: trig = per_tick;
            default:       trig = 1'b0;
        endcase
        if (masked) begin
            trig = 1'b0;
        end
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sar_d    = sar_q;
        ts_cap_d = ts_cap_q;
        sync1_d  = hit;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        edge_d   = sync2_q & ~prev_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d  = ST_HOLD;
                    cnt_d    = '0;
                    ts_cap_d = ts;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                state_d = ST_CONVERT;
                cnt_d   = '0;
                sar_d   = '0;
            end
            ST_CONVERT: begin
                // Keep the trial bit when vin >= DAC; otherwise it stays 0.
                if (comp) begin
                    sar_d = sar_q | trial;
                end
                if (cnt_q == CONV_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (ack) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            end
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        sample    = (state_q == ST_SAMPLE);
        strobe    = (state_q == ST_CONVERT);
        csa_reset = (state_q == ST_RESET);
        ready     = (state_q == ST_READY);
        dac_word  = '0;
        if (state_q == ST_CONVERT) begin
            dac_word = sar_q | trial;
        end else if (state_q == ST_READY) begin
            dac_word = sar_q;
        end
        result = sar_q;
        ts_cap = ts_cap_q;
    end

endmodule

// File: rtl/channel_array_ctrl.sv
// ---------------------------------------------------------------------------
// channel_array_ctrl
// Sequences NUM_CHANNELS analog channels (trigger, hold, sample, SAR
// conversion, CSA reset) and streams their event records through a
// round-robin arbiter onto a valid/ready output.
// Ports:
//   clk, reset                 clock, async active-high reset
//   hit, comp                  per-channel discriminator / comparator inputs
//   mode, ext_trig, period     trigger configuration
//   channel_mask               1 disables new triggers on that channel
//   sample, strobe, csa_reset  per-channel front-end controls
//   dac_word                   per-channel SAR trial word, ADCBITS per channel
//   out_valid/out_ready        record handshake
//   out_chan, out_adc, out_ts  record fields
// ---------------------------------------------------------------------------
module channel_array_ctrl
    import channel_ctrl_pkg::*;
#(
    parameter int  NUM_CHANNELS = 4,
    parameter int  ADCBITS      = 10,
    parameter int  TS_BITS      = 16,
    parameter int  HOLD_CYCLES  = 2,
    parameter int  RESET_CYCLES = 4,
    localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CHANNELS-1:0]         hit,
    input  logic [NUM_CHANNELS-1:0]         comp,
    input  logic [1:0]                      mode,
    input  logic                            ext_trig,
    input  logic [TS_BITS-1:0]              period,
    input  logic [NUM_CHANNELS-1:0]         channel_mask,
    output logic [NUM_CHANNELS-1:0]         sample,
    output logic [NUM_CHANNELS-1:0]         strobe,
    output logic [NUM_CHANNELS-1:0]         csa_reset,
    output logic [NUM_CHANNELS*ADCBITS-1:0] dac_word,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHAN_W-1:0]               out_chan,
    output logic [ADCBITS-1:0]              out_adc,
    output logic [TS_BITS-1:0]              out_ts
);

    logic [TS_BITS-1:0]      ts_q, ts_d;
    logic [TS_BITS-1:0]      per_cnt_q, per_cnt_d;
    logic                    per_tick;
    logic [CHAN_W-1:0]       ptr_q, ptr_d;
    logic                    out_valid_q, out_valid_d;
    event_rec_t              rec_q, rec_d;
    logic [NUM_CHANNELS-1:0] ready, pend, cand, ack;
    logic [ADCBITS-1:0]      result [NUM_CHANNELS];
    logic [TS_BITS-1:0]      ts_cap [NUM_CHANNELS];
    logic                    load, found;
    logic [CHAN_W-1:0]       sel;
    int                      idx;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        channel_fsm #(
            .ADCBITS      (ADCBITS),
            .TS_BITS      (TS_BITS),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .RESET_CYCLES (RESET_CYCLES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .hit       (hit[g]),
            .comp      (comp[g]),
            .mode      (mode),
            .ext_trig  (ext_trig),
            .per_tick  (per_tick),
            .masked    (channel_mask[g]),
            .ts        (ts_q),
            .ack       (ack[g]),
            .sample    (sample[g]),
            .strobe    (strobe[g]),
            .csa_reset (csa_reset[g]),
            .dac_word  (dac_word[g*ADCBITS +: ADCBITS]),
            .ready     (ready[g]),
            .result    (result[g]),
            .ts_cap    (ts_cap[g])
        );
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q        <= '0;
            per_cnt_q   <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            ts_q        <= ts_d;
            per_cnt_q   <= per_cnt_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
        end
    end

    // Timestamp and periodic trigger. The >= compare keeps the counter from
    // running away if period is lowered below the current count.
    always_comb begin
        ts_d      = ts_q + TS_BITS'(1);
        per_tick  = 1'b0;
        per_cnt_d = per_cnt_q + TS_BITS'(1);
        if (period == '0) begin
            per_cnt_d = '0;
        end else if (per_cnt_q >= period - TS_BITS'(1)) begin
            per_tick  = 1'b1;
            per_cnt_d = '0;
        end
    end

    // Arbitration and output register. The channel whose record sits in the
    // output register stays READY until transferred, so it is excluded from
    // the search; this lets the next record load on the transfer cycle.
    always_comb begin
        pend = '0;
        if (out_valid_q) begin
            pend = NUM_CHANNELS'(1) << rec_q.chan[CHAN_W-1:0];
        end
        ack  = pend & {NUM_CHANNELS{out_ready}};
        cand = ready & ~pend;
        load = !out_valid_q || out_ready;

        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CHANNELS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = CHAN_W'(idx);
            end
        end

        ptr_d       = ptr_q;
        rec_d       = rec_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                ptr_d     = (int'(sel) == NUM_CHANNELS - 1) ? '0 : sel + CHAN_W'(1);
                rec_d.chan = CHAN_MAX_W'(sel);
                rec_d.adc  = ADC_MAX_W'(result[sel]);
                rec_d.ts   = TS_MAX_W'(ts_cap[sel]);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = rec_q.chan[CHAN_W-1:0];
    assign out_adc   = rec_q.adc[ADCBITS-1:0];
    assign out_ts    = rec_q.ts[TS_BITS-1:0];

endmodule

// File: tb/tb_channel_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_channel_array_ctrl
// Self-checking bench for channel_array_ctrl with default parameters.
// Each channel's comparator is modelled as (target >= dac_word).
// ---------------------------------------------------------------------------
module tb_channel_array_ctrl;

    localparam int NCH = 4;
    localparam int AB  = 10;

    typedef struct packed {
        logic [1:0]  chan;
        logic [9:0]  adc;
        logic [15:0] ts;
    } rec_t;

    localparam logic [9:0] TGT [NCH] = '{10'h155, 10'h2A5, 10'h3FF, 10'h001};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  hit;
    logic [3:0]  comp;
    logic [1:0]  mode;
    logic        ext_trig;
    logic [15:0] period;
    logic [3:0]  channel_mask;
    logic [3:0]  sample;
    logic [3:0]  strobe;
    logic [3:0]  csa_reset;
    logic [39:0] dac_word;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_chan;
    logic [9:0]  out_adc;
    logic [15:0] out_ts;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    rec_t        exp_q [$];
    rec_t        obs [$];
    int          obs_cyc [$];
    logic [15:0] tb_ts;
    int          cyc = 0;
    int          samp_cnt [NCH];
    int          strobe_cnt [NCH];
    int          csa_cnt [NCH];
    logic [15:0] samp_ts [NCH];
    logic [9:0]  first_dac [NCH];

    channel_array_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .hit          (hit),
        .comp         (comp),
        .mode         (mode),
        .ext_trig     (ext_trig),
        .period       (period),
        .channel_mask (channel_mask),
        .sample       (sample),
        .strobe       (strobe),
        .csa_reset    (csa_reset),
        .dac_word     (dac_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_chan     (out_chan),
        .out_adc      (out_adc),
        .out_ts       (out_ts)
    );

    always #5 clk = ~clk;

    // Comparator model: 1 when the analog input is at or above the DAC.
    always_comb begin
        comp = '0;
        for (int c = 0; c < NCH; c++) begin
            comp[c] = (TGT[c] >= dac_word[c*AB +: AB]);
        end
    end

    // Reference timestamp: the value the DUT counter holds in each cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records transfers and per-channel activity, cleared by reset.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            obs.delete();
            obs_cyc.delete();
            for (int c = 0; c < NCH; c++) begin
                samp_cnt[c]   <= 0;
                strobe_cnt[c] <= 0;
                csa_cnt[c]    <= 0;
                samp_ts[c]    <= '0;
                first_dac[c]  <= '0;
            end
        end else begin
            if (out_valid && out_ready) begin
                obs.push_back('{out_chan, out_adc, out_ts});
                obs_cyc.push_back(cyc);
            end
            for (int c = 0; c < NCH; c++) begin
                if (sample[c]) begin
                    samp_cnt[c] <= samp_cnt[c] + 1;
                    samp_ts[c]  <= tb_ts;
                end
                if (strobe[c]) begin
                    if (strobe_cnt[c] == 0) first_dac[c] <= dac_word[c*AB +: AB];
                    strobe_cnt[c] <= strobe_cnt[c] + 1;
                end
                if (csa_reset[c]) csa_cnt[c] <= csa_cnt[c] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [3:0] msk, input logic [15:0] per);
        reset        = 1'b1;
        hit          = '0;
        ext_trig     = 1'b0;
        out_ready    = 1'b1;
        mode         = m;
        channel_mask = msk;
        period       = per;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({sample, strobe, csa_reset, dac_word} !== 52'd0) begin
            $display("[TB] FAIL reset_ctrl: got %h required 0", {sample, strobe, csa_reset, dac_word});
        end else pass_cnt++;
        total_cnt++;
        if ({out_valid, out_chan, out_adc, out_ts} !== 29'd0) begin
            $display("[TB] FAIL reset_out: got %h required 0", {out_valid, out_chan, out_adc, out_ts});
        end else pass_cnt++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_self_trigger();
        logic [15:0] t;
        rec_t        e;
        int          rd = 0;
        do_reset(2'd0, 4'b0000, 16'd0);
        repeat (3) tick();
        t      = tb_ts;
        hit[1] = 1'b1;
        // Edge seen after two synchronizer flops and the edge register.
        exp_q.push_back('{2'd1, TGT[1], 16'(t + 16'd3)});
        repeat (2) tick();
        hit[1] = 1'b0;
        wait_obs(1, 80);
        repeat (10) tick();
        total_cnt++;
        if (samp_cnt[1] !== 1 || samp_ts[1] !== 16'(t + 16'd6)) begin
            $display("[TB] FAIL self_sample: got count %0d at ts %0d, required 1 at %0d", samp_cnt[1], samp_ts[1], 16'(t + 16'd6));
        end else pass_cnt++;
        total_cnt++;
        if (strobe_cnt[1] !== 10) $display("[TB] FAIL self_strobes: got %0d required 10", strobe_cnt[1]);
        else pass_cnt++;
        total_cnt++;
        if (first_dac[1] !== 10'h200) $display("[TB] FAIL self_first_dac: got %h required 200", first_dac[1]);
        else pass_cnt++;
        total_cnt++;
        if (csa_cnt[1] !== 4) $display("[TB] FAIL self_csa: got %0d required 4", csa_cnt[1]);
        else pass_cnt++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (rd >= obs.size()) $display("[TB] FAIL self_rec: missing, required %0d/%h/%h", e.chan, e.adc, e.ts);
            else if (obs[rd] !== e) $display("[TB] FAIL self_rec: got %0d/%h/%h required %0d/%h/%h", obs[rd].chan, obs[rd].adc, obs[rd].ts, e.chan, e.adc, e.ts);
            else pass_cnt++;
            rd++;
        end
    endtask

    task automatic test_ext_round_robin();
        rec_t e;
        int   rd = 0;
        int   gap;
        do_reset(2'd1, 4'b0000, 16'd0);
        repeat (2) tick();
        ext_trig = 1'b1;
        for (int c = 0; c < NCH; c++) exp_q.push_back('{2'(c), TGT[c], tb_ts});
        tick();
        ext_trig = 1'b0;
        wait_obs(4, 60);
        gap = (obs_cyc.size() >= 4) ? obs_cyc[3] - obs_cyc[0] : -1;
        total_cnt++;
        if (gap !== 3) $display("[TB] FAIL ext_back_to_back: got span %0d required 3", gap);
        else pass_cnt++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (rd >= obs.size()) $display("[TB] FAIL ext_rec: missing, required %0d/%h/%h", e.chan, e.adc, e.ts);
            else if (obs[rd] !== e) $display("[TB] FAIL ext_rec: got %0d/%h/%h required %0d/%h/%h", obs[rd].chan, obs[rd].adc, obs[rd].ts, e.chan, e.adc, e.ts);
            else pass_cnt++;
            rd++;
        end
    endtask

    task automatic test_backpressure();
        rec_t        e;
        int          rd = 0;
        logic [13:0] held;
        logic        stable = 1'b1;
        do_reset(2'd0, 4'b0000, 16'd0);
        out_ready = 1'b0;
        tick();
        hit[2] = 1'b1;
        exp_q.push_back('{2'd2, TGT[2], 16'(tb_ts + 16'd3)});
        repeat (2) tick();
        hit[2] = 1'b0;
        for (int i = 0; i < 60 && !out_valid; i++) tick();
        held = {out_chan, out_adc, out_valid, 1'b0};
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 3) hit[2] = 1'b1;
            if (i == 5) hit[2] = 1'b0;
            if ({out_chan, out_adc, out_valid, 1'b0} !== held || held[1] !== 1'b1) stable = 1'b0;
        end
        total_cnt++;
        if (stable !== 1'b1) $display("[TB] FAIL bp_stable: got %b required 1", stable);
        else pass_cnt++;
        total_cnt++;
        if (dac_word[2*AB +: AB] !== TGT[2] || csa_reset[2] !== 1'b0) begin
            $display("[TB] FAIL bp_ready_hold: got dac %h csa %b required %h 0", dac_word[2*AB +: AB], csa_reset[2], TGT[2]);
        end else pass_cnt++;
        out_ready = 1'b1;
        wait_obs(1, 10);
        repeat (40) tick();
        total_cnt++;
        if (obs.size() !== 1) $display("[TB] FAIL bp_hit_dropped: got %0d records required 1", obs.size());
        else pass_cnt++;
        total_cnt++;
        if (csa_cnt[2] !== 4) $display("[TB] FAIL bp_csa: got %0d required 4", csa_cnt[2]);
        else pass_cnt++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (rd >= obs.size()) $display("[TB] FAIL bp_rec: missing, required %0d/%h/%h", e.chan, e.adc, e.ts);
            else if (obs[rd] !== e) $display("[TB] FAIL bp_rec: got %0d/%h/%h required %0d/%h/%h", obs[rd].chan, obs[rd].adc, obs[rd].ts, e.chan, e.adc, e.ts);
            else pass_cnt++;
            rd++;
        end
    endtask

    task automatic test_periodic_mask();
        rec_t e;
        int   rd = 0;
        logic [15:0] tsv [2] = '{16'd99, 16'd199};
        do_reset(2'd2, 4'b0100, 16'd100);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{2'd0, TGT[0], tsv[k]});
            exp_q.push_back('{2'd1, TGT[1], tsv[k]});
            exp_q.push_back('{2'd3, TGT[3], tsv[k]});
        end
        wait_obs(6, 320);
        total_cnt++;
        if (samp_cnt[2] !== 0 || csa_cnt[2] !== 0) $display("[TB] FAIL per_masked: got %0d samples required 0", samp_cnt[2]);
        else pass_cnt++;
        total_cnt++;
        if (samp_cnt[0] !== 2) $display("[TB] FAIL per_count: got %0d required 2", samp_cnt[0]);
        else pass_cnt++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (rd >= obs.size()) $display("[TB] FAIL per_rec: missing, required %0d/%h/%h", e.chan, e.adc, e.ts);
            else if (obs[rd] !== e) $display("[TB] FAIL per_rec: got %0d/%h/%h required %0d/%h/%h", obs[rd].chan, obs[rd].adc, obs[rd].ts, e.chan, e.adc, e.ts);
            else pass_cnt++;
            rd++;
        end
    endtask

    task automatic test_mid_conv_reset();
        int n = 0;
        do_reset(2'd1, 4'b0000, 16'd0);
        tick();
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            tick();
            if (strobe[0]) n++;
        end
        total_cnt++;
        if (n !== 6) $display("[TB] FAIL mid_reach_cycle5: got %0d strobes required 6", n);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({sample, strobe, csa_reset, dac_word, out_valid, out_chan, out_adc, out_ts} !== 81'd0) begin
            $display("[TB] FAIL mid_outputs_zero: got %h required 0", {sample, strobe, csa_reset, dac_word, out_valid});
        end else pass_cnt++;
        repeat (2) tick();
        reset = 1'b0;
        repeat (40) tick();
        total_cnt++;
        if (obs.size() !== 0 || out_valid !== 1'b0) $display("[TB] FAIL mid_no_record: got %0d records required 0", obs.size());
        else pass_cnt++;
    endtask

    task automatic test_ts_wrap();
        rec_t e;
        int   rd = 0;
        do_reset(2'd1, 4'b1110, 16'd0);
        for (int i = 0; i < 70000 && tb_ts != 16'hFFFF; i++) tick();
        ext_trig = 1'b1;
        exp_q.push_back('{2'd0, TGT[0], tb_ts});
        tick();
        ext_trig = 1'b0;
        wait_obs(1, 60);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (rd >= obs.size()) $display("[TB] FAIL wrap_rec: missing, required %0d/%h/%h", e.chan, e.adc, e.ts);
            else if (obs[rd] !== e || e.ts !== 16'hFFFF) $display("[TB] FAIL wrap_rec: got %0d/%h/%h required %0d/%h/ffff", obs[rd].chan, obs[rd].adc, obs[rd].ts, e.chan, e.adc);
            else pass_cnt++;
            rd++;
        end
    endtask

    initial begin
        hit          = '0;
        ext_trig     = 1'b0;
        out_ready    = 1'b1;
        mode         = 2'd3;
        channel_mask = '0;
        period       = '0;
        #2;
        test_reset();
        test_self_trigger();
        test_ext_round_robin();
        test_backpressure();
        test_periodic_mask();
        test_mid_conv_reset();
        test_ts_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
